i2c_reg_seq: RTL

- Parametrised I2C register-transaction sequencer; successor to the fixed single-command sensor sequencers.
- Sits between user logic and the byte-level I2C master, which it drives through the start/send/datasend/sended/receive/datareceive/received/isReady interface.
- Executes one register read (burst of 1..MAX_LEN bytes, with restart) or one register write (burst of 1..MAX_LEN bytes) per command.
- Holds payload in an internal byte buffer with separate user write and read ports.

---
 rtl/i2c_reg_seq.sv | 238 +++++++++++++++++++++++
 1 files changed

// File: rtl/i2c_reg_seq.sv
// Register-transaction sequencer in front of a byte-level I2C master: one burst register read (with restart)
// or one burst register write per command. Define I2C_REG_SEQ_TIMEOUT_EN to build the watchdog abort.
module i2c_reg_seq #(
  parameter logic [6:0] DEV_ADR     = 7'h77,
  parameter int         MAX_LEN     = 22,
  parameter int         LEN_W       = 5,
  parameter int         DELAY_START = 15,
  parameter int         TIMEOUT     = 65535
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_go,
  input  logic             cmd_rw,
  input  logic [7:0]       cmd_reg,
  input  logic [LEN_W-1:0] cmd_len,
  input  logic             buf_we,
  input  logic [LEN_W-1:0] buf_waddr,
  input  logic [7:0]       buf_wdata,
  input  logic [LEN_W-1:0] buf_raddr,
  output logic [7:0]       buf_rdata,
  output logic             busy,
  output logic             done,
  output logic             err,
  input  logic             isReady,
  output logic             start,
  output logic             send,
  output logic [7:0]       datasend,
  input  logic             sended,
  output logic             receive,
  input  logic [7:0]       datareceive,
  input  logic             received
);

  typedef enum logic [2:0] {
    IDLE, WAIT_RDY, SLA_W, REG, WDATA, SLA_R, RDATA, FINISH
  } stateT;

  // The per-byte phase counter must reach at least 2 so that the send/receive pulse at count 1 is single-cycle.
  localparam int CNT_MAX = (DELAY_START < 2) ? 2 : DELAY_START;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  stateT            state, stateNext;
  logic [LEN_W-1:0] idx, idxNext;
  logic [LEN_W-1:0] len, lenNext;
  logic [CNT_W-1:0] cnt, cntNext;
  logic             cmdRw, rwNext;
  logic [7:0]       cmdReg, regNext;
  logic             errNext;
  logic             sendedD, receivedD;
  logic [7:0]       mem [MAX_LEN];

  logic             sendedEv, receivedEv, bytePhase, capture, lastByte, active, wdHit;
  logic [LEN_W-1:0] lenClamped;
  logic [7:0]       bufAtIdx, rdataMux;
  logic [MAX_LEN-1:0] capSel, userSel;

  assign sendedEv   = sended & ~sendedD;
  assign receivedEv = received & ~receivedD;
  assign bytePhase  = (cnt != '0);
  assign capture    = (state == RDATA) && receivedEv && bytePhase;
  assign lastByte   = (idx == (len - LEN_W'(1)));
  assign lenClamped = (cmd_len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : cmd_len;
  assign active     = state inside {WAIT_RDY, SLA_W, REG, WDATA, SLA_R, RDATA};

`ifdef I2C_REG_SEQ_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT + 1);
  logic [WD_W-1:0] wdCnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wdCnt <= '0;
    end else if (stateNext != state) begin
      wdCnt <= '0;
    end else if (wdCnt != WD_W'(TIMEOUT)) begin
      wdCnt <= wdCnt + WD_W'(1);
    end
  end

  assign wdHit = active && (wdCnt == WD_W'(TIMEOUT));
`else
  localparam bit unusedTimeout = (TIMEOUT != 0);
  assign wdHit = 1'b0;
`endif

  genvar gi;
  generate
    for (gi = 0; gi < MAX_LEN; gi++) begin : gSel
      assign capSel[gi]  = capture && (idx == LEN_W'(gi));
      assign userSel[gi] = buf_we && (buf_waddr == LEN_W'(gi));
    end
  endgenerate

  always_comb begin
    bufAtIdx = 8'h00;
    rdataMux = 8'h00;
    for (int i = 0; i < MAX_LEN; i++) begin
      if (idx == LEN_W'(i)) bufAtIdx = mem[i];
      if (buf_raddr == LEN_W'(i)) rdataMux = mem[i];
    end
  end

  assign buf_rdata = rdataMux;

  always_comb begin
    stateNext = state;
    idxNext   = idx;
    lenNext   = len;
    rwNext    = cmdRw;
    regNext   = cmdReg;
    errNext   = err;
    cntNext   = (cnt == CNT_W'(CNT_MAX)) ? cnt : cnt + CNT_W'(1);
    case (state)
      IDLE: begin
        if (cmd_go) begin
          rwNext  = cmd_rw;
          regNext = cmd_reg;
          lenNext = lenClamped;
          idxNext = '0;
          if (lenClamped == '0) begin
            stateNext = FINISH;
            errNext   = 1'b1;
          end else begin
            stateNext = WAIT_RDY;
            errNext   = 1'b0;
          end
        end
      end
      WAIT_RDY: if (isReady) stateNext = SLA_W;
      SLA_W:    if (sendedEv && bytePhase) stateNext = REG;
      REG:      if (sendedEv && bytePhase) stateNext = cmdRw ? SLA_R : WDATA;
      WDATA: begin
        if (sendedEv && bytePhase) begin
          if (lastByte) begin
            stateNext = FINISH;
          end else begin
            idxNext = idx + LEN_W'(1);
            cntNext = '0;
          end
        end
      end
      SLA_R:    if (sendedEv && bytePhase) stateNext = RDATA;
      RDATA: begin
        if (capture) begin
          if (lastByte) begin
            stateNext = FINISH;
          end else begin
            idxNext = idx + LEN_W'(1);
            cntNext = '0;
          end
        end
      end
      FINISH:   stateNext = IDLE;
      default:  stateNext = IDLE;
    endcase
    if (wdHit) begin
      stateNext = FINISH;
      errNext   = 1'b1;
    end
    if (stateNext != state) cntNext = '0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      idx       <= '0;
      len       <= '0;
      cnt       <= '0;
      cmdRw     <= 1'b0;
      cmdReg    <= 8'h00;
      err       <= 1'b0;
      sendedD   <= 1'b0;
      receivedD <= 1'b0;
    end else begin
      state     <= stateNext;
      idx       <= idxNext;
      len       <= lenNext;
      cnt       <= cntNext;
      cmdRw     <= rwNext;
      cmdReg    <= regNext;
      err       <= errNext;
      sendedD   <= sended;
      receivedD <= received;
    end
  end

  // A bus capture takes priority over a user write to the same entry in the same cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < MAX_LEN; i++) mem[i] <= 8'h00;
    end else begin
      for (int i = 0; i < MAX_LEN; i++) begin
        if (capSel[i]) begin
          mem[i] <= datareceive;
        end else if (userSel[i]) begin
          mem[i] <= buf_wdata;
        end
      end
    end
  end

  always_comb begin
    start    = 1'b0;
    send     = 1'b0;
    receive  = 1'b0;
    datasend = 8'h00;
    case (state)
      SLA_W: begin
        datasend = {DEV_ADR, 1'b0};
        start    = (cnt < CNT_W'(DELAY_START));
        send     = (cnt == CNT_W'(1));
      end
      REG: begin
        datasend = cmdReg;
        send     = (cnt == CNT_W'(1));
      end
      WDATA: begin
        datasend = bufAtIdx;
        send     = (cnt == CNT_W'(1));
      end
      SLA_R: begin
        datasend = {DEV_ADR, 1'b1};
        start    = (cnt < CNT_W'(DELAY_START));
        send     = (cnt == CNT_W'(1));
      end
      RDATA:   receive = (cnt == CNT_W'(1));
      default: ;
    endcase
    if (wdHit) begin
      start   = 1'b0;
      send    = 1'b0;
      receive = 1'b0;
    end
  end

  assign busy = active;
  assign done = (state == FINISH);

endmodule
